// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if: external memory port of the fetch/data arbiter.
// master = arbiter side (drives the request), slave = memory side.
interface mem_port_arbiter_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic            m_req;
    logic            m_we;
    logic [DW/8-1:0] m_be;
    logic [AW-1:0]   m_addr;
    logic [DW-1:0]   m_wdata;
    logic            m_gnt;
    logic            m_rvalid;
    logic [DW-1:0]   m_rdata;

    modport master (
        output m_req, m_we, m_be, m_addr, m_wdata,
        input  m_gnt, m_rvalid, m_rdata
    );

    modport slave (
        input  m_req, m_we, m_be, m_addr, m_wdata,
        output m_gnt, m_rvalid, m_rdata
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory port between the instruction fetch
// requester (I) and the data requester (D) of an RV32I core. One transaction
// outstanding at a time; round-robin when both request together.
// Optional macro MEM_ARB_TIMEOUT_EN adds an issue-to-response watchdog that
// completes a stuck transaction with rdata=0 and raises a sticky timeout_err.
module mem_port_arbiter #(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int TIMEOUT = 255
) (
    input  logic            clk,
    input  logic            rst_n,
    // fetch requester
    input  logic            i_req,
    input  logic [AW-1:0]   i_addr,
    output logic            i_ack,
    output logic [DW-1:0]   i_rdata,
    // data requester
    input  logic            d_req,
    input  logic            d_we,
    input  logic [DW/8-1:0] d_be,
    input  logic [AW-1:0]   d_addr,
    input  logic [DW-1:0]   d_wdata,
    output logic            d_ack,
    output logic [DW-1:0]   d_rdata,
    // memory port
    mem_port_arbiter_if.master mem,
    // status
    output logic            busy,
    output logic            timeout_err
);

    localparam int BW = DW / 8;

    // owner encoding: 0 = fetch, 1 = data
    localparam logic OWN_I = 1'b0;
    localparam logic OWN_D = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
    } state_t;

    state_t          r_state;
    state_t          w_state_next;
    logic            r_owner;
    logic            r_last_owner;
    logic            r_we;
    logic [BW-1:0]   r_be;
    logic [AW-1:0]   r_addr;
    logic [DW-1:0]   r_wdata;

    logic            w_any_req;
    logic            w_pick_d;
    logic            w_resp;
    logic            w_timeout;
    logic            w_done;
    logic [DW-1:0]   w_rsp_data;

    // Arbitration: a lone requester wins; on contention the one not served last wins.
    always_comb begin
        w_any_req = i_req | d_req;
        w_pick_d  = d_req & (~i_req | (r_last_owner == OWN_I));
    end

`ifdef MEM_ARB_TIMEOUT_EN
    // Counter is at least 8 bits and wide enough to hold TIMEOUT.
    localparam int CW = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;

    logic [CW-1:0] r_cnt;
    logic          r_timeout_err;

    // Fires on the TIMEOUT-th cycle spent in ISSUE/WAIT unless a real response lands then.
    always_comb begin
        w_timeout = ((r_state == ST_ISSUE) ||
                     ((r_state == ST_WAIT) && !mem.m_rvalid)) &&
                    (r_cnt == CW'(TIMEOUT - 1));
    end

    // Watchdog counter: held at zero in IDLE so it starts from zero on ISSUE entry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt         <= '0;
            r_timeout_err <= 1'b0;
        end else begin
            if (r_state == ST_IDLE || w_timeout) begin
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
            if (w_timeout) begin
                r_timeout_err <= 1'b1;
            end
        end
    end

    assign timeout_err = r_timeout_err;
`else
    logic [31:0] w_unused_timeout;

    assign w_unused_timeout = TIMEOUT;
    assign w_timeout        = 1'b0;
    assign timeout_err      = 1'b0;
`endif

    // Completion: a response is only honoured in WAIT; a timeout completes with zero data.
    always_comb begin
        w_resp     = (r_state == ST_WAIT) && mem.m_rvalid;
        w_done     = w_resp || w_timeout;
        w_rsp_data = w_resp ? mem.m_rdata : '0;
    end

    // Next-state logic; a completion always returns to IDLE.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_any_req) begin
                    w_state_next = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (mem.m_gnt) begin
                    w_state_next = ST_WAIT;
                end
            end
            ST_WAIT: begin
                w_state_next = ST_WAIT;
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
        if (w_done) begin
            w_state_next = ST_IDLE;
        end
    end

    // State, owner and latched payload registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_owner      <= OWN_I;
            r_last_owner <= OWN_I;
            r_we         <= 1'b0;
            r_be         <= '0;
            r_addr       <= '0;
            r_wdata      <= '0;
        end else begin
            r_state <= w_state_next;
            if (r_state == ST_IDLE && w_any_req) begin
                r_owner <= w_pick_d ? OWN_D : OWN_I;
                if (w_pick_d) begin
                    r_we    <= d_we;
                    r_be    <= d_be;
                    r_addr  <= d_addr;
                    r_wdata <= d_wdata;
                end else begin
                    // fetches are always full-word reads
                    r_we    <= 1'b0;
                    r_be    <= '1;
                    r_addr  <= i_addr;
                    r_wdata <= '0;
                end
            end
            if (w_done) begin
                r_last_owner <= r_owner;
            end
        end
    end

    // Memory request outputs: driven only in ISSUE, zero otherwise.
    always_comb begin
        mem.m_req   = 1'b0;
        mem.m_we    = 1'b0;
        mem.m_be    = '0;
        mem.m_addr  = '0;
        mem.m_wdata = '0;
        if (r_state == ST_ISSUE) begin
            mem.m_req   = 1'b1;
            mem.m_we    = r_we;
            mem.m_be    = r_be;
            mem.m_addr  = r_addr;
            mem.m_wdata = r_wdata;
        end
    end

    // Response routing: only the owner sees ack/data, and data is zero without ack.
    always_comb begin
        i_ack   = 1'b0;
        d_ack   = 1'b0;
        i_rdata = '0;
        d_rdata = '0;
        if (w_done) begin
            if (r_owner == OWN_D) begin
                d_ack   = 1'b1;
                d_rdata = w_rsp_data;
            end else begin
                i_ack   = 1'b1;
                i_rdata = w_rsp_data;
            end
        end
    end

    assign busy = (r_state != ST_IDLE);

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one external memory port between the fetch stage (instruction requester I) and the memory stage (data requester D) of the 5-stage RV32I core.
- Latches the winning request, drives the memory request until it is granted, then waits for the response and routes it back with a single-cycle ack.
- One transaction is outstanding at a time.
- The core derives stallF = i_req & ~i_ack and stallM = d_req & ~d_ack.

Parameters:
- AW, 32, address width.
- DW, 32, data width; byte enables are DW/8 bits wide.
- TIMEOUT, 255, maximum cycles from issue to response. Used only with MEM_ARB_TIMEOUT_EN.

Ports:
- clk  in  1  clock; all flops on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- i_req  in  1  fetch request; held with i_addr until i_ack.
- i_addr  in  AW  fetch address.
- i_ack  out  1  fetch response valid, one cycle.
- i_rdata  out  DW  instruction word, valid when i_ack.
- d_req  in  1  data request; held with payload until d_ack.
- d_we  in  1  1 = store, 0 = load.
- d_be  in  DW/8  store byte enables.
- d_addr  in  AW  data address.
- d_wdata  in  DW  store data.
- d_ack  out  1  data response valid, one cycle.
- d_rdata  out  DW  load data, valid when d_ack.
- m_req  out  1  memory request.
- m_we  out  1  memory write.
- m_be  out  DW/8  memory byte enables.
- m_addr  out  AW  memory address.
- m_wdata  out  DW  memory write data.
- m_gnt  in  1  memory accepted request (handshake with m_req).
- m_rvalid  in  1  memory response; read data or write completion.
- m_rdata  in  DW  memory read data.
- busy  out  1  state != IDLE.
- timeout_err  out  1  sticky timeout flag.

Behaviour:
- States: IDLE, ISSUE, WAIT. Registered: owner (I/D), last_owner, latched we/be/addr/wdata.
- Reset (async, rst_n=0):
  - state=IDLE, owner=I, last_owner=I, latched fields=0, timeout_err=0.
  - m_req, i_ack, d_ack, busy all 0.
  - Reset mid-transaction aborts it immediately, with no ack; a response arriving later is ignored.
- IDLE:
  - Only d_req: owner=D.
  - Only i_req: owner=I.
  - Both asserted: owner = opposite of last_owner, giving round-robin, no starvation.
  - Any request: latch the payload (fetch forces we=0, be=all-ones, wdata=0), then go to ISSUE next cycle.
  - Neither asserted: stay in IDLE.
- ISSUE:
  - m_req=1; m_we/m_be/m_addr/m_wdata come from the latched fields.
  - m_gnt=1 moves to WAIT.
  - m_req/m_we/m_be/m_addr/m_wdata remain 0 outside ISSUE.
- WAIT:
  - m_rvalid=1 (combinational path): owner's ack=1 and owner's rdata=m_rdata for that cycle; last_owner=owner; next state IDLE.
  - The requester may present a new request in the very next cycle; arbitration restarts in IDLE.
  - Minimum latency, request to ack: 3 cycles (IDLE, ISSUE with gnt, WAIT with rvalid).
- Non-owner ack is always 0. Non-owner rdata=0. Owner rdata=0 when ack=0.
- m_rvalid outside WAIT is ignored.
- m_gnt and m_rvalid in the same ISSUE cycle: only the grant is honoured. The memory must not respond in its grant cycle.
- A requester must not change its payload or drop req before its ack; behaviour otherwise is undefined.
- Stores complete on m_rvalid; d_rdata is unused for stores.

Optional Feature:
- Macro: MEM_ARB_TIMEOUT_EN.
- With the macro defined:
  - An 8-bit-or-wider counter clears on entry to ISSUE and increments each cycle in ISSUE/WAIT.
  - If it reaches TIMEOUT with no m_rvalid, the owner gets ack=1 with rdata=0 and the state returns to IDLE.
  - timeout_err sets and stays set until reset.
- Without it: no counter; the block waits indefinitely and timeout_err is tied to 0.

Test Plan:
- Fetch only: i_req=1, i_addr=0x100; m_gnt on first ISSUE cycle; m_rvalid 2 cycles later with m_rdata=0x00500093 -> m_addr=0x100, m_we=0; i_ack pulses once with i_rdata=0x00500093; d_ack stays 0.
- Store: d_req=1, d_we=1, d_be=0xF, d_addr=0x2000, d_wdata=0xDEADBEEF -> m_req with m_we=1, m_be=0xF, m_addr=0x2000, m_wdata=0xDEADBEEF held until m_gnt; d_ack on m_rvalid.
- Contention: i_req and d_req both held after reset (last_owner=I) -> D served first (d_ack), I served next (i_ack); with both held again, order keeps alternating.
- Grant backpressure: m_gnt low for 5 cycles -> m_req and payload stable for all 5 cycles; exactly one transaction issued.
- Mid-transaction reset: rst_n=0 in WAIT -> m_req=0, busy=0, no ack; a later m_rvalid with rst_n=1 produces no ack.
- MEM_ARB_TIMEOUT_EN with TIMEOUT=16: m_gnt given, m_rvalid never -> ack with rdata=0 at cycle 16, timeout_err=1 and sticky; the next fetch completes normally.
